ofm_packer: RTL and testbench

- Sits directly downstream of the 16-lane PE cluster.
- Captures one set of 16 8-bit OFM lanes when every enabled lane reports valid.
- Packs the set into four 32-bit words and streams them, with write addresses, to the OFM buffer over a valid/ready handshake.
- Tracks tile completion and flags result sets dropped because the buffer side stalled.

---
 rtl/ofm_packer.sv | 134 +++++++++++++
 tb/tb_ofm_packer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_packer.sv
//============================================================================
// Module  : ofm_packer
// Purpose : Captures a 16-lane OFM result set and streams it as four 32-bit
//           words with write addresses to the OFM buffer.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module ofm_packer #(
  parameter int ADDR_W     = 10,
  parameter int TILE_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [127:0]      ofm_in,
  input  logic [15:0]       valid_in,
  input  logic [15:0]       ch_mask,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              tile_done,
  output logic              overflow
);

  localparam int CNT_W = $clog2(TILE_WORDS + 1);
  localparam logic [CNT_W-1:0] c_tile_last = CNT_W'(TILE_WORDS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  logic [3:0][31:0]    r_set;
  logic [1:0]          r_beat;
  logic [CNT_W-1:0]    r_tile_cnt;

  logic [127:0]        w_lane_mask;
  logic [127:0]        w_set;
  logic                w_capture;
  logic                w_accept;
  logic                w_last;
  logic [1:0]          w_beat_nxt;

  generate
    for (genvar i = 0; i < 16; i++) begin : g_lane
      assign w_lane_mask[8*i +: 8] = {8{ch_mask[i]}};
    end
  endgenerate

  // Disabled lanes are zeroed so packed words never carry stale PE data.
  assign w_set      = ofm_in & w_lane_mask;
  assign w_capture  = (ch_mask != 16'h0000) && ((valid_in & ch_mask) == ch_mask);
  assign w_accept   = out_valid & out_ready;
  assign w_last     = (r_beat == 2'd3);
  assign w_beat_nxt = r_beat + 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_set      <= '0;
      r_beat     <= 2'd0;
      r_tile_cnt <= '0;
      out_data   <= 32'h0;
      out_addr   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      tile_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      if (start) begin
        // A new tile overrides everything, including a same-cycle capture.
        r_state    <= S_IDLE;
        r_beat     <= 2'd0;
        r_tile_cnt <= '0;
        out_addr   <= base_addr;
        out_valid  <= 1'b0;
        busy       <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_capture) begin
              r_set     <= w_set;
              out_data  <= w_set[31:0];
              r_beat    <= 2'd0;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              r_state   <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (w_accept) begin
              out_addr <= out_addr + ADDR_W'(1);
              if (r_tile_cnt == c_tile_last) begin
                r_tile_cnt <= '0;
                tile_done  <= 1'b1;
              end else begin
                r_tile_cnt <= r_tile_cnt + CNT_W'(1);
              end
              if (w_last) begin
                r_beat <= 2'd0;
                if (w_capture) begin
                  // Back-to-back set: reload without an idle cycle.
                  r_set    <= w_set;
                  out_data <= w_set[31:0];
                end else begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
                end
              end else begin
                r_beat   <= w_beat_nxt;
                out_data <= r_set[w_beat_nxt];
              end
            end
            if (w_capture && !(w_accept && w_last)) begin
              overflow <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ofm_packer.sv
//============================================================================
// Module  : tb_ofm_packer
// Purpose : Self-checking bench for ofm_packer (table, directed, random).
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module tb_ofm_packer;

  localparam int AW = 10;
  localparam int TW = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [127:0]   ofm_in;
  logic [15:0]    valid_in;
  logic [15:0]    ch_mask;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [31:0]    out_data;
  logic [AW-1:0]  out_addr;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic           tile_done;
  logic           overflow;

  always #5 clk = ~clk;

  ofm_packer #(.ADDR_W(AW), .TILE_WORDS(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ofm_in    (ofm_in),
    .valid_in  (valid_in),
    .ch_mask   (ch_mask),
    .start     (start),
    .base_addr (base_addr),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .tile_done (tile_done),
    .overflow  (overflow)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of words still owed to the buffer.
  logic [31:0]   m_q[$];
  logic [AW-1:0] m_addr;
  int            m_tcnt;
  logic          m_ovf;
  logic          m_td;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_word(input logic [127:0] ofm, input logic [15:0] m, input int k);
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      int lane;
      lane = 4 * k + j;
      if (m[lane]) w = w | (32'(ofm[8*lane +: 8]) << (8 * j));
    end
    return w;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_addr = '0;
    m_tcnt = 0;
    m_ovf  = 1'b0;
    m_td   = 1'b0;
  endtask

  task automatic model_edge();
    bit cap;
    bit was_busy;
    if (!reset_n) begin
      m_reset();
      return;
    end
    m_td = 1'b0;
    if (start) begin
      m_q.delete();
      m_addr = base_addr;
      m_tcnt = 0;
      m_ovf  = 1'b0;
      return;
    end
    cap      = (ch_mask != 16'h0) && ((valid_in & ch_mask) == ch_mask);
    was_busy = (m_q.size() > 0);
    if (was_busy && out_ready) begin
      void'(m_q.pop_front());
      m_addr = m_addr + 1'b1;
      m_tcnt++;
      if (m_tcnt == TW) begin
        m_tcnt = 0;
        m_td   = 1'b1;
      end
    end
    if (cap) begin
      if (m_q.size() == 0) begin
        for (int k = 0; k < 4; k++) m_q.push_back(pack_word(ofm_in, ch_mask, k));
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_q.size() > 0);
    chk("busy", busy, m_q.size() > 0);
    chk("tile_done", tile_done, m_td);
    chk("overflow", overflow, m_ovf);
    if (m_q.size() > 0) begin
      chk("out_data", out_data, m_q[0]);
      chk("out_addr", out_addr, m_addr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic [15:0]   valid;
    logic          ready;
    logic          e_valid;
    logic          e_busy;
    logic [31:0]   e_data;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [127:0]  set_b;
    logic [31:0]   prev_data;
    logic [AW-1:0] prev_addr;
    logic          stalled;
    bit            sent;
    int            td_cnt;
    logic [AW-1:0] seen_addr[$];
    logic [AW-1:0] exp_addr;

    tbl[0] = '{1'b1, 10'h100, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0,        10'h000};
    tbl[1] = '{1'b0, 10'h000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 32'h04030201, 10'h100};
    tbl[2] = '{1'b0, 10'h000, 16'h0000, 1'b1, 1'b1, 1'b1, 32'h08070605, 10'h101};
    tbl[3] = '{1'b0, 10'h000, 16'h0000, 1'b1, 1'b1, 1'b1, 32'h0C0B0A09, 10'h102};
    tbl[4] = '{1'b0, 10'h000, 16'h0000, 1'b1, 1'b1, 1'b1, 32'h100F0E0D, 10'h103};
    tbl[5] = '{1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0,        10'h000};

    // Reset, then idle
    reset_n = 1'b0; ofm_in = '0; valid_in = '0; ch_mask = 16'hFFFF;
    start = 1'b0; base_addr = '0; out_ready = 1'b1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_data", out_data, 32'h0);
      chk("reset_addr", out_addr, '0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_data", out_data, 32'h0);
      chk("idle_addr", out_addr, '0);
    end

    // Single capture from the table
    for (int i = 0; i < 16; i++) ofm_in[8*i +: 8] = 8'(i + 1);
    for (int r = 0; r < 6; r++) begin
      start = tbl[r].start; base_addr = tbl[r].base;
      valid_in = tbl[r].valid; out_ready = tbl[r].ready;
      tick();
      chk($sformatf("tbl%0d_valid", r), out_valid, tbl[r].e_valid);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      if (tbl[r].e_valid) begin
        chk($sformatf("tbl%0d_data", r), out_data, tbl[r].e_data);
        chk($sformatf("tbl%0d_addr", r), out_addr, tbl[r].e_addr);
      end
    end

    // Back-pressure and back-to-back sets
    start = 1'b1; base_addr = 10'h200; valid_in = '0; tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) ofm_in[8*i +: 8] = 8'hA0 + 8'(i);
    valid_in = 16'hFFFF; out_ready = 1'b0; tick();
    set_b = {$urandom, $urandom, $urandom, $urandom};
    ofm_in = set_b;
    sent = 0;
    for (int i = 0; i < 20 && !sent; i++) begin
      out_ready = (i % 3 == 0);
      valid_in  = (m_q.size() == 1 && out_ready) ? 16'hFFFF : 16'h0000;
      sent      = (valid_in != 16'h0000);
      stalled   = out_valid && !out_ready;
      prev_data = out_data; prev_addr = out_addr;
      tick();
      if (stalled) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_addr", out_addr, prev_addr);
      end
    end
    chk("b2b_sent", sent, 1'b1);
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_addr", out_addr, 10'h204);
    chk("b2b_data", out_data, pack_word(set_b, 16'hFFFF, 0));
    valid_in = '0; out_ready = 1'b1;
    for (int i = 0; i < 8 && out_valid; i++) tick();
    chk("b2b_ovf", overflow, 1'b0);

    // Partial mask and drop
    start = 1'b1; base_addr = 10'h000; tick();
    start = 1'b0;
    ch_mask = 16'h00FF; ofm_in = {$urandom, $urandom, $urandom, $urandom};
    valid_in = 16'h00FF; out_ready = 1'b0; tick();
    chk("pm_capture", out_valid, 1'b1);
    tick();
    chk("pm_drop_ovf", overflow, 1'b1);
    valid_in = '0; out_ready = 1'b1;
    tick();
    tick(); chk("pm_word2", out_data, 32'h0);
    tick(); chk("pm_word3", out_data, 32'h0);
    tick(); chk("pm_idle", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("pm_ovf_sticky", overflow, 1'b1);
    ch_mask = 16'hFFFF;
    start = 1'b1; tick();
    start = 1'b0;
    chk("pm_ovf_clear", overflow, 1'b0);

    // Tile completion and address wrap
    start = 1'b1; base_addr = 10'h3FE; tick();
    start = 1'b0; out_ready = 1'b1;
    ofm_in = {$urandom, $urandom, $urandom, $urandom};
    valid_in = 16'hFFFF; tick();
    sent = 0; td_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      valid_in = (!sent && m_q.size() == 1) ? 16'hFFFF : 16'h0000;
      if (valid_in != 16'h0000) sent = 1;
      if (out_valid && out_ready) seen_addr.push_back(out_addr);
      tick();
      if (tile_done) td_cnt++;
    end
    chk("tile_words", seen_addr.size(), 8);
    exp_addr = 10'h3FE;
    foreach (seen_addr[i]) begin
      chk($sformatf("wrap_addr%0d", i), seen_addr[i], exp_addr);
      exp_addr = exp_addr + 1'b1;
    end
    chk("tile_done_count", td_cnt, 1);

    // Start mid-drain after a drop
    start = 1'b1; base_addr = 10'h300; tick();
    start = 1'b0; valid_in = 16'hFFFF; out_ready = 1'b0; tick();
    tick();
    chk("md_ovf", overflow, 1'b1);
    valid_in = '0; out_ready = 1'b1;
    tick(); tick();
    start = 1'b1; base_addr = 10'h020; tick();
    chk("md_valid_low", out_valid, 1'b0);
    chk("md_ovf_clear", overflow, 1'b0);
    start = 1'b0; out_ready = 1'b0; tick();
    valid_in = 16'hFFFF; tick();
    valid_in = '0;
    chk("md_addr", out_addr, 10'h020);

    // Asynchronous reset in the middle of a drain
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_data", out_data, 32'h0);
    chk("ar_addr", out_addr, '0);
    chk("ar_ovf", overflow, 1'b0);
    tick(); tick();
    reset_n = 1'b1; tick();
    valid_in = 16'hFFFF; tick();
    valid_in = '0;
    chk("ar_cap_valid", out_valid, 1'b1);
    chk("ar_cap_addr", out_addr, 10'h000);

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      start     = ($urandom_range(0, 99) == 0);
      base_addr = AW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (m_q.size() == 0 && $urandom_range(0, 7) == 0) ch_mask = 16'($urandom);
      ofm_in = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: valid_in = 16'hFFFF;
        1: valid_in = ch_mask;
        2: valid_in = 16'($urandom);
        default: valid_in = 16'h0000;
      endcase
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
